// File: rtl/mul_digit_serial.sv
// Digit-serial unsigned multiplier/accumulator.
// Operand b is consumed two bits per cycle, LSB digit first; each digit's
// partial product (a x digit) is shifted into place and added to a working
// sum. In accumulate mode the working sum starts from the previous result,
// so consecutive products can be summed for convolution MACs.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | ready for an operand pair; clear may zero the result
//  RUN   | one 2-bit digit of b per cycle folded into the working sum
//  DONE  | result presented; held until downstream takes it
module mul_digit_serial #(
   parameter int W     = 8,
   parameter int ACC_W = 2*W+4
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic             acc_mode,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] result,
   output logic             busy
);

   localparam int D  = W/2;
   localparam int CW = (D > 1) ? $clog2(D) : 1;
   localparam logic [CW-1:0] K_LAST = CW'(D-1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic [CW-1:0]    k;
   logic [ACC_W-1:0] sum;
   logic [ACC_W-1:0] result_q;

   logic [W-1:0]     b_shift;
   logic [1:0]       digit;
   logic [W+1:0]     pp;
   logic [ACC_W-1:0] pp_shift;
   logic [ACC_W-1:0] sum_next;

   // Partial product of the current digit, aligned to bit 2k, added to the sum.
   always_comb begin
      b_shift  = b_q >> {k, 1'b0};
      digit    = b_shift[1:0];
      pp       = ({2'b00, a_q}      & {(W+2){digit[0]}})
               + ({1'b0, a_q, 1'b0} & {(W+2){digit[1]}});
      pp_shift = ACC_W'(pp) << {k, 1'b0};
      sum_next = sum + pp_shift;
   end

   // Control FSM with operand latches, digit index, working sum and result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         k        <= '0;
         sum      <= '0;
         result_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (clear)
                  result_q <= '0;
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  k     <= '0;
                  // A clear in the same cycle wins over accumulation.
                  sum   <= (acc_mode && !clear) ? result_q : '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sum <= sum_next;
               k   <= k + CW'(1);
               if (k == K_LAST) begin
                  result_q <= sum_next;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake flags are pure state decodes; no input reaches them combinationally.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
      result    = result_q;
   end

endmodule

// File: tb/tb_mul_digit_serial.sv
// Self-checking bench for mul_digit_serial: directed cases plus randomized
// operations, with a scoreboard queue fed from a plain-arithmetic model.
module tb_mul_digit_serial;

   localparam int W     = 8;
   localparam int ACC_W = 20;
   localparam int D     = W/2;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     a_in = '0;
   logic [W-1:0]     b_in = '0;
   logic             acc_mode = 1'b0;
   logic             clear = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [ACC_W-1:0] result;
   logic             busy;

   int checks = 0;
   int errors = 0;

   logic [ACC_W-1:0] exp_q[$];
   logic [ACC_W-1:0] model = '0;
   logic [ACC_W-1:0] cur_exp = '0;
   logic [ACC_W-1:0] cur_rp = '0;
   bit               pulse_clear = 1'b0;
   bit               toggle_in = 1'b0;
   bit               seen = 1'b0;

   mul_digit_serial #(.W(W), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_in),
      .b         (b_in),
      .acc_mode  (acc_mode),
      .clear     (clear),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   // Scoreboard monitor: one comparison per entry into the result-valid phase.
   always @(negedge clk) begin
      if (!reset) begin
         seen = 1'b0;
      end else if (out_valid && !seen) begin
         seen = 1'b1;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual=%0d required=no_output", result);
         end else begin
            chk("sb_result", result, exp_q.pop_front());
         end
      end else if (!out_valid) begin
         seen = 1'b0;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) timeout("wait_in_ready");
   endtask

   // Offer one operand pair; when push is set, predict the result.
   task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit acc, input bit clr, input bit push);
      logic [ACC_W-1:0] base;
      wait_idle();
      base   = (acc && !clr) ? model : '0;
      cur_rp = clr ? '0 : model;
      if (push) begin
         cur_exp = base + ACC_W'(int'(av) * int'(bv));
         model   = cur_exp;
         exp_q.push_back(cur_exp);
      end
      in_valid = 1'b1;
      a_in     = av;
      b_in     = bv;
      acc_mode = acc;
      clear    = clr;
      @(posedge clk); #1;
      in_valid = 1'b0;
      clear    = 1'b0;
      a_in     = W'($urandom);
      b_in     = W'($urandom);
   endtask

   // Follow the operation through RUN and DONE; hold > 0 applies backpressure.
   task automatic finish(input int hold);
      int n = 0;
      out_ready = (hold == 0);
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (pulse_clear) clear = (n == 1);
         if (!out_valid) begin
            chk("run_in_ready", in_ready, 0);
            chk("run_busy", busy, 1);
            chk("run_result_stable", result, cur_rp);
         end
      end
      clear = 1'b0;
      if (!out_valid) begin
         timeout("wait_out_valid");
         return;
      end
      chk("latency", n, D);
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            if (toggle_in) begin
               in_valid = ~in_valid;
               a_in     = W'($urandom);
               b_in     = W'($urandom);
               acc_mode = 1'($urandom);
            end
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 1);
            chk("bp_result", result, cur_exp);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk("exit_out_valid", out_valid, 0);
      chk("exit_in_ready", in_ready, 1);
      chk("exit_result", result, cur_exp);
   endtask

   task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv,
                     input bit acc, input bit clr, input int hold);
      issue(av, bv, acc, clr, 1'b1);
      finish(hold);
   endtask

   initial begin
      #3;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result", result, 0);
      #9 reset = 1'b1;

      op(8'd255, 8'd255, 1'b0, 1'b0, 0);
      chk("full_scale", result, 65025);

      op(8'd3, 8'd5, 1'b0, 1'b0, 0);
      chk("mul_3x5", result, 15);
      op(8'd7, 8'd9, 1'b1, 1'b0, 0);
      chk("acc_78", result, 78);
      op(8'd2, 8'd2, 1'b0, 1'b0, 0);
      chk("restart_4", result, 4);

      op(8'd255, 8'd255, 1'b0, 1'b0, 0);
      for (int i = 1; i < 17; i++) op(8'd255, 8'd255, 1'b1, 1'b0, 0);
      chk("wrap_final", result, 56849);

      toggle_in = 1'b1;
      op(8'd3, 8'd4, 1'b0, 1'b0, 10);
      toggle_in = 1'b0;
      chk("bp_final", result, 12);

      issue(8'd200, 8'd201, 1'b0, 1'b0, 1'b0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_result", result, 0);
      model = '0;
      #2 reset = 1'b1;
      op(8'd2, 8'd3, 1'b1, 1'b0, 0);
      chk("post_rst_6", result, 6);

      op(8'd3, 8'd5, 1'b0, 1'b0, 0);
      op(8'd7, 8'd9, 1'b1, 1'b0, 0);
      op(8'd10, 8'd12, 1'b1, 1'b1, 0);
      chk("clear_with_accept", result, 120);
      pulse_clear = 1'b1;
      op(8'd1, 8'd1, 1'b1, 1'b0, 0);
      pulse_clear = 1'b0;
      chk("clear_in_run_ignored", result, 121);
      op(8'd0, 8'd99, 1'b0, 1'b0, 0);
      chk("zero_a", result, 0);
      op(8'd77, 8'd0, 1'b0, 1'b0, 0);
      chk("zero_b", result, 0);

      op(8'd6, 8'd7, 1'b0, 1'b0, 0);
      wait_idle();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      model = '0;
      chk("clear_idle", result, 0);

      for (int i = 0; i < 40; i++) begin
         toggle_in = 1'($urandom);
         op(W'($urandom), W'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
      end
      toggle_in = 1'b0;

      repeat (3) @(posedge clk);
      chk("sb_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
